// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver with glitch filter, parity/framing checks and watchdog
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out,
  output logic       new_byte,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [13:0] WDOG_LAST = 14'(TIMEOUT - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        clk_s;
  logic        data_s;
  logic [3:0]  filt_cnt;
  logic        filt_clk;
  logic        filt_prev;
  logic        fall;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n;
  logic [13:0] wdog, wdog_n;
  logic [7:0]  out_n;
  logic        new_byte_n, parity_err_n, frame_err_n, timeout_err_n;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = filt_prev & ~filt_clk;
  assign busy   = (state != IDLE);

  // Two-flop synchronisers for both raw pins; idle level of the bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered clock only follows the synced clock after FILTER_LEN agreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt  <= 4'd0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_cnt <= 4'd0;
        filt_clk <= clk_s;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // Frame state register together with datapath and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      par         <= 1'b0;
      wdog        <= 14'd0;
      out         <= 8'h00;
      new_byte    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      par         <= par_n;
      wdog        <= wdog_n;
      out         <= out_n;
      new_byte    <= new_byte_n;
      parity_err  <= parity_err_n;
      frame_err   <= frame_err_n;
      timeout_err <= timeout_err_n;
    end
  end

  // Next-state logic: bits are taken on filtered falling edges; a fall always beats the watchdog
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    par_n         = par;
    wdog_n        = wdog;
    out_n         = out;
    new_byte_n    = 1'b0;
    parity_err_n  = 1'b0;
    frame_err_n   = 1'b0;
    timeout_err_n = 1'b0;
    if (fall) begin
      wdog_n = 14'd0;
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shift_n   = {data_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_s) begin
            frame_err_n = 1'b1;
          end else if (^{shift, par}) begin
            out_n      = shift;
            new_byte_n = 1'b1;
          end else begin
            parity_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state == IDLE) begin
      wdog_n = 14'd0;
    end else if (wdog == WDOG_LAST) begin
      state_n       = IDLE;
      bit_cnt_n     = 3'd0;
      wdog_n        = 14'd0;
      timeout_err_n = 1'b1;
    end else begin
      wdog_n = wdog + 14'd1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx
module tb_ps2_rx;

  localparam int FL      = 8;
  localparam int TO      = 400;
  localparam int HALF    = 40;

  localparam logic [3:0] K_NEW = 4'b0001;
  localparam logic [3:0] K_PAR = 4'b0010;
  localparam logic [3:0] K_FRM = 4'b0100;
  localparam logic [3:0] K_TO  = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] out;
  logic       new_byte, parity_err, frame_err, timeout_err, busy;

  exp_t       sb[$];
  logic [7:0] model_out = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         t_fall = 0;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out(out), .new_byte(new_byte), .parity_err(parity_err),
    .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device drives data while the clock is high; optional short low glitch in the high phase
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    t_fall  = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      tick(5);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(HALF / 2 - 8);
    end else begin
      tick(HALF / 2);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop, input int glitch_bit);
    logic [10:0] f;
    exp_t e;
    f = frame_bits(d, bad_par, stop);
    e.data = d;
    if (!stop) e.kind = K_FRM;
    else if (bad_par) e.kind = K_PAR;
    else e.kind = K_NEW;
    sb.push_back(e);
    for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
  endtask

  task automatic send_partial(input logic [7:0] d, input int n);
    logic [10:0] f;
    f = frame_bits(d, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Scoreboard: every status pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (new_byte | parity_err | frame_err | timeout_err)) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed=%b expected=none",
               {timeout_err, frame_err, parity_err, new_byte});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pulse_kind", {28'd0, timeout_err, frame_err, parity_err, new_byte}, {28'd0, e.kind});
        if (e.kind == K_NEW) model_out = e.data;
        check("out_at_pulse", {24'd0, out}, {24'd0, model_out});
      end
    end
  end

  initial begin
    int w;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b0;
    tick(3);
    check("reset_out", {24'd0, out}, 32'h0);
    check("reset_pulses", {28'd0, timeout_err, frame_err, parity_err, new_byte}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    tick(5);

    // single good frame
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    drain("t1_drain");
    check("t1_out", {24'd0, out}, 32'h1C);
    check("t1_busy", {31'd0, busy}, 32'h0);

    // back-to-back frames
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    drain("t2_drain");
    check("t2_out", {24'd0, out}, 32'h1C);

    // parity error, then framing error with bad parity too
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    drain("t3_par_drain");
    check("t3_par_out", {24'd0, out}, 32'h1C);
    send_frame(8'h1C, 1'b1, 1'b0, -1);
    drain("t3_frm_drain");
    check("t3_frm_out", {24'd0, out}, 32'h1C);

    // glitch in idle, then glitch mid-data
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    check("t4_idle_busy", {31'd0, busy}, 32'h0);
    send_frame(8'h76, 1'b0, 1'b1, 3);
    drain("t4_drain");
    check("t4_out", {24'd0, out}, 32'h76);

    // stalled frame: start + 4 data bits then clock held high
    send_partial(8'h55, 5);
    check("t5_busy_stall", {31'd0, busy}, 32'h1);
    sb.push_back('{kind: K_TO, data: 8'h00});
    w = 0;
    while (!timeout_err && w < 2 * TO) begin
      @(negedge clk);
      w++;
    end
    check("t5_timeout_seen", {31'd0, timeout_err}, 32'h1);
    check("t5_timeout_lat_ok", ((cyc - t_fall) >= TO + FL && (cyc - t_fall) <= TO + FL + 5) ? 32'h1 : 32'h0, 32'h1);
    tick(2);
    check("t5_busy_after", {31'd0, busy}, 32'h0);
    check("t5_out_kept", {24'd0, out}, 32'h76);
    drain("t5_to_drain");
    send_frame(8'h76, 1'b0, 1'b1, -1);
    drain("t5_drain");
    check("t5_out", {24'd0, out}, 32'h76);

    // reset mid-frame after data bit 5
    send_partial(8'h29, 7);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", {24'd0, out}, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'h0);
    check("t6_rst_pulses", {28'd0, timeout_err, frame_err, parity_err, new_byte}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_out = 8'h00;
    tick(2 * HALF);
    check("t6_idle_after", {31'd0, busy}, 32'h0);
    send_frame(8'h29, 1'b0, 1'b1, -1);
    drain("t6_drain");
    check("t6_out", {24'd0, out}, 32'h29);

    tick(20);
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host serial receiver. It deserialises the 11-bit PS/2 frame (start, 8 data bits LSB first, odd parity, stop) from the raw keyboard pins into scancode bytes. It sits directly upstream of the scancode-to-ASCII stage: out drives that stage's in, and new_byte drives its new_in. It also adds glitch filtering, parity and framing checks, and a stalled-frame watchdog.

Parameters:
FILTER_LEN, 8, consecutive identical clk samples required before the filtered PS/2 clock changes level (range 2..15).
TIMEOUT, 10000, clk cycles without a PS/2 falling edge before an in-progress frame is abandoned (200 us at 50 MHz; 14-bit counter).

Ports:
clk  input  1  system clock, all logic on posedge.
rst_n  input  1  reset, asynchronous, active-low.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
out  output  8  last correctly received byte.
new_byte  output  1  one-cycle pulse: out holds a new valid byte.
parity_err  output  1  one-cycle pulse: frame dropped, bad parity.
frame_err  output  1  one-cycle pulse: frame dropped, stop bit was 0.
timeout_err  output  1  one-cycle pulse: frame abandoned by watchdog.
busy  output  1  high while state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out=0x00; new_byte, parity_err, frame_err, timeout_err, busy = 0.
- Reset also sets: sync flops and filtered clock = 1; bit counter, shift register and watchdog = 0.
- Synchroniser: ps2_clk and ps2_data each pass through 2 flops.
- Filter: filt_clk goes 0 only after FILTER_LEN consecutive synced-0 samples. It goes 1 only after FILTER_LEN consecutive synced-1 samples. Shorter pulses are ignored.
- Edge: fall = filt_clk_prev & ~filt_clk. All bit sampling happens on fall, using synced ps2_data in that cycle.
- FSM, on fall:
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift right, sampled bit into bit 7 (LSB-first assembly). bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: always -> IDLE, with exactly one of:
    - stop=1 and XOR(8 data bits, parity)=1: out<=shift, new_byte=1.
    - stop=1 and parity check fails: parity_err=1, out unchanged.
    - stop=0: frame_err=1, out unchanged. frame_err takes priority over parity_err.
- Latency: status pulses are registered. They are high in the cycle after the cycle where fall is detected on the stop bit, for exactly one cycle. out changes in the same cycle new_byte rises and holds until the next good frame.
- Pin-to-pulse latency: 2 sync + FILTER_LEN + 1 cycles after the raw stop-bit falling edge.
- Watchdog:
  - Cleared in IDLE and on every fall.
  - Otherwise increments each clk.
  - On reaching TIMEOUT: state->IDLE, bit_cnt=0, timeout_err pulse, out unchanged.
  - If a fall and the timeout occur in the same cycle, the fall wins: it is processed and the watchdog clears.
- Back-to-back frames: a start bit in the first fall after STOP->IDLE is accepted. No gap is required beyond PS/2 timing.
- Reset mid-frame aborts the frame immediately. No pulses are emitted.
- busy=1 from the cycle after the start-bit fall until the cycle state returns to IDLE.

Test Plan:
1. Send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz -> out=0x1C, single new_byte pulse, no error pulses, busy low afterwards.
2. Send 0xF0 (parity 1) then 0x1C back-to-back -> two new_byte pulses, out=0xF0 then 0x1C. Each out value is stable while new_byte is high.
3. Send 0x1C with parity 1 -> one parity_err pulse, no new_byte, out keeps its prior value. Then send 0x1C with stop=0 and parity 1 -> frame_err only.
4. Glitch: with FILTER_LEN=8, inject 3-cycle low pulses on ps2_clk in IDLE and mid-DATA -> no state change, no bit shifted. A following clean frame 0x76 -> out=0x76.
5. Stall: send start + 4 data bits, hold ps2_clk high -> timeout_err exactly TIMEOUT cycles after the last fall, busy drops. A following frame 0x76 is received correctly.
6. Assert rst_n=0 for 1 cycle after bit 5 of a frame -> all outputs 0 immediately (async), no pulses. The next full frame 0x29 -> out=0x29.
